ex_muldiv_ctrl: RTL

EX_MULDIV_CTRL -- requirements
Module: ex_muldiv_ctrl

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/muldiv_dp.sv | 55 +++++
 rtl/ex_muldiv_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: datapath width plus the mul/div opcode and controller state enums.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MD_MUL   = 2'd0,
    MD_MULHU = 2'd1,
    MD_DIVU  = 2'd2,
    MD_REMU  = 2'd3
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_div_op(input muldiv_op_e op);
    return (op == MD_DIVU) || (op == MD_REMU);
  endfunction

endpackage

// File: rtl/muldiv_dp.sv
// Bit-serial unsigned datapath: shift-add multiply or restoring divide, one operand bit per step.
// acc holds the product high half / partial remainder, shreg the multiplier / quotient.
module muldiv_dp #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] shreg_nxt
);

  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] shreg;
  logic [XLEN-1:0] opnd;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic            div_ok;

  always_comb begin
    mul_sum   = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
    div_shift = {acc, shreg[XLEN-1]};
    div_ok    = div_shift >= {1'b0, opnd};
    div_diff  = div_shift - {1'b0, opnd};
    if (is_div) begin
      acc_nxt   = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      shreg_nxt = {shreg[XLEN-2:0], div_ok};
    end else begin
      acc_nxt   = mul_sum[XLEN:1];
      shreg_nxt = {mul_sum[0], shreg[XLEN-1:1]};
    end
  end

  // Multiply shifts the multiplier out of shreg; divide shifts the dividend out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      shreg <= '0;
      opnd  <= '0;
    end else if (load) begin
      acc   <= '0;
      shreg <= is_div ? a : b;
      opnd  <= is_div ? b : a;
    end else if (step) begin
      acc   <= acc_nxt;
      shreg <= shreg_nxt;
    end
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage iterative multiply/divide controller: FSM, pipeline stall/done and result select.
// Optional MULDIV_EARLY_OUT_EN finishes a zero-divisor/zero-multiplier op without iterating.
//   state | meaning
//   IDLE  | waiting for StartE
//   CALC  | first cycle loads the datapath, then one operand bit per cycle
//   DONE  | ResultE valid, DoneE pulses, pipeline released
module ex_muldiv_ctrl #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            FlushE,
  input  logic            StartE,
  input  logic [1:0]      OpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  output logic            StallE,
  output logic            DoneE,
  output logic [XLEN-1:0] ResultE,
  output logic            BusyE
);

  import riscv_pkg::*;

  localparam int CW = $clog2(XLEN + 1);

  muldiv_state_e   state;
  muldiv_state_e   state_nxt;
  logic [CW-1:0]   count;
  logic            loaded;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  muldiv_op_e      op_q;
  logic            start_ok;
  logic            early;
  logic            finish;
  logic            dp_load;
  logic            dp_step;
  logic            res_load;
  logic [XLEN-1:0] acc_nxt;
  logic [XLEN-1:0] shreg_nxt;
  logic [XLEN-1:0] final_res;
  logic [XLEN-1:0] res_nxt;

  assign start_ok = (state == IDLE) && StartE && !FlushE;
  assign dp_load  = (state == CALC) && !loaded;
  assign dp_step  = (state == CALC) && loaded && !FlushE;
  assign finish   = dp_step && (count == CW'(1));

`ifdef MULDIV_EARLY_OUT_EN
  logic [XLEN-1:0] early_res;

  assign early = start_ok && (SrcBE == '0);

  always_comb begin
    early_res = '0;
    case (muldiv_op_e'(OpE))
      MD_DIVU: early_res = '1;
      MD_REMU: early_res = SrcAE;
      default: early_res = '0;
    endcase
  end
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = early ? DONE : CALC;
      end
      CALC: begin
        if (FlushE)      state_nxt = IDLE;
        else if (finish) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // StallE is masked during reset because StartE may still be held by the pipeline.
  always_comb begin
    StallE = !rst && (start_ok || (state == CALC));
    DoneE  = (state == DONE) && !FlushE;
    BusyE  = (state != IDLE);
  end

  // The last step's combinational output is captured so ResultE updates on DONE entry.
  always_comb begin
    final_res = '0;
    case (op_q)
      MD_MUL:   final_res = shreg_nxt;
      MD_MULHU: final_res = acc_nxt;
      MD_DIVU:  final_res = shreg_nxt;
      MD_REMU:  final_res = acc_nxt;
      default:  final_res = '0;
    endcase
    res_load = finish;
    res_nxt  = final_res;
`ifdef MULDIV_EARLY_OUT_EN
    if (early) begin
      res_load = 1'b1;
      res_nxt  = early_res;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      loaded  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= MD_MUL;
      ResultE <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        a_q    <= SrcAE;
        b_q    <= SrcBE;
        op_q   <= muldiv_op_e'(OpE);
        count  <= CW'(XLEN);
        loaded <= 1'b0;
      end else if (dp_load) begin
        loaded <= 1'b1;
      end else if (dp_step) begin
        count <= count - CW'(1);
      end
      if (res_load) ResultE <= res_nxt;
    end
  end

  muldiv_dp #(.XLEN(XLEN)) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load      (dp_load),
    .step      (dp_step),
    .is_div    (is_div_op(op_q)),
    .a         (a_q),
    .b         (b_q),
    .acc_nxt   (acc_nxt),
    .shreg_nxt (shreg_nxt)
  );

endmodule
